seg_scan_ctrl: RTL

- Display scheduler for the traffic-light countdowns.
- Time-shares a single internal bcd_8421 converter between two 8-bit countdown channels, A (north-south) and B (east-west).
- Drives a 4-digit multiplexed common-anode 7-segment display: tens and units per channel.
- Sits between the countdown/timer logic and the board display pins.

---
 rtl/seg_scan_ctrl.sv | 211 +++++++++++++++++++++
 1 files changed

// File: rtl/seg_scan_ctrl.sv
// seg_scan_ctrl: display scheduler for the traffic-light countdowns.
//
// One shared binary-to-BCD converter serves two 8-bit countdown channels,
// A (north-south) and B (east-west). The results drive a 4-digit multiplexed
// common-anode 7-segment display: A tens, A units, B tens, B units.
//
// Both channels are converted back to back at the start of every frame. All
// four digits of a frame therefore come from one snapshot, and a value never
// tears across digits.
//
// Parameters:
//   SCAN_CNT_MAX  scan tick period minus 1, in sys_clk cycles
//   BLANK_LEAD    1: a tens digit of 0 is blanked, 0: it shows "0"
//
// Ports:
//   sys_clk    system clock, rising edge
//   sys_rst_n  asynchronous active-low reset
//   en         display enable; 0 blanks the display and parks the scheduler
//   data_a     channel A countdown value (binary)
//   data_b     channel B countdown value (binary)
//   sel        digit select, active-low one-hot, registered
//   seg        segments {dp,g,f,e,d,c,b,a}, active-low, registered
module seg_scan_ctrl #(
    parameter int unsigned SCAN_CNT_MAX = 49_999,
    parameter bit          BLANK_LEAD   = 1'b1
) (
    input  logic       sys_clk,
    input  logic       sys_rst_n,
    input  logic       en,
    input  logic [7:0] data_a,
    input  logic [7:0] data_b,
    output logic [3:0] sel,
    output logic [7:0] seg
);

    localparam int unsigned CNT_W = (SCAN_CNT_MAX > 0) ? $clog2(SCAN_CNT_MAX + 1) : 1;

    typedef enum logic [1:0] {StIdle, StConvA, StConvB, StShow} state_e;

    state_e             state_q, state_d;
    logic [CNT_W-1:0]   scan_cnt_q, scan_cnt_d;
    logic [1:0]         idx_q, idx_d;
    logic [7:0]         bcd_a_q, bcd_a_d;
    logic [7:0]         bcd_b_q, bcd_b_d;
    logic               valid_q, valid_d;
    logic [3:0]         sel_q, sel_d;
    logic [7:0]         seg_q, seg_d;

    logic               tick;
    logic [7:0]         conv_in;
    logic [7:0]         conv_clamped;
    logic [7:0]         conv_bcd;
    logic [3:0]         digit;
    logic               digit_is_tens;
    logic [3:0]         sel_dec;
    logic [7:0]         seg_dec;

    // Active-low segment pattern for one decimal digit.
    function automatic logic [7:0] seg_code(input logic [3:0] d);
        case (d)
            4'd0:    seg_code = 8'hC0;
            4'd1:    seg_code = 8'hF9;
            4'd2:    seg_code = 8'hA4;
            4'd3:    seg_code = 8'hB0;
            4'd4:    seg_code = 8'h99;
            4'd5:    seg_code = 8'h92;
            4'd6:    seg_code = 8'h82;
            4'd7:    seg_code = 8'hF8;
            4'd8:    seg_code = 8'h80;
            4'd9:    seg_code = 8'h90;
            default: seg_code = 8'hFF;
        endcase
    endfunction

    assign tick = (scan_cnt_q == CNT_W'(SCAN_CNT_MAX));

    // Shared converter: the FSM state picks which channel is sampled.
    always_comb begin
        conv_in      = (state_q == StConvB) ? data_b : data_a;
        conv_clamped = (conv_in > 8'd99) ? 8'd99 : conv_in;
    end

    // Shift-add-3 conversion. Inputs never exceed 99, so two BCD digits hold
    // the whole result and nothing is shifted out of the top.
    always_comb begin
        conv_bcd = '0;
        for (int i = 7; i >= 0; i--) begin
            if (conv_bcd[3:0] > 4'd4) begin
                conv_bcd[3:0] = conv_bcd[3:0] + 4'd3;
            end
            if (conv_bcd[7:4] > 4'd4) begin
                conv_bcd[7:4] = conv_bcd[7:4] + 4'd3;
            end
            conv_bcd = {conv_bcd[6:0], conv_clamped[i]};
        end
    end

    // Digit select and segment pattern for the current scan position.
    always_comb begin
        digit         = 4'd0;
        digit_is_tens = 1'b0;
        sel_dec       = 4'b1111;
        unique case (idx_q)
            2'd0: begin
                digit         = bcd_a_q[7:4];
                digit_is_tens = 1'b1;
                sel_dec       = 4'b1110;
            end
            2'd1: begin
                digit         = bcd_a_q[3:0];
                sel_dec       = 4'b1101;
            end
            2'd2: begin
                digit         = bcd_b_q[7:4];
                digit_is_tens = 1'b1;
                sel_dec       = 4'b1011;
            end
            2'd3: begin
                digit         = bcd_b_q[3:0];
                sel_dec       = 4'b0111;
            end
            default: ;
        endcase
        if (BLANK_LEAD && digit_is_tens && (digit == 4'd0)) begin
            seg_dec = 8'hFF;
        end else begin
            seg_dec = seg_code(digit);
        end
    end

    always_comb begin
        state_d    = state_q;
        scan_cnt_d = scan_cnt_q;
        idx_d      = idx_q;
        bcd_a_d    = bcd_a_q;
        bcd_b_d    = bcd_b_q;
        valid_d    = valid_q;
        sel_d      = sel_q;
        seg_d      = seg_q;

        if (!en) begin
            state_d    = StIdle;
            scan_cnt_d = '0;
            idx_d      = 2'd0;
            valid_d    = 1'b0;
            sel_d      = 4'b1111;
            seg_d      = 8'hFF;
        end else begin
            unique case (state_q)
                StIdle: state_d = StConvA;
                StConvA: begin
                    bcd_a_d = conv_bcd;
                    state_d = StConvB;
                end
                StConvB: begin
                    bcd_b_d = conv_bcd;
                    valid_d = 1'b1;
                    state_d = StShow;
                end
                StShow: begin
                    if (tick) begin
                        scan_cnt_d = '0;
                        idx_d      = idx_q + 2'd1;
                        if (idx_q == 2'd3) begin
                            state_d = StConvA;
                        end
                    end else begin
                        scan_cnt_d = scan_cnt_q + CNT_W'(1);
                    end
                end
                default: state_d = StIdle;
            endcase

            if (!valid_q) begin
                sel_d = 4'b1111;
                seg_d = 8'hFF;
            end else if (state_q == StShow) begin
                sel_d = sel_dec;
                seg_d = seg_dec;
            end
            // While a refresh converts, the last digit of the previous frame
            // stays lit, so the new snapshot first appears on the idx0 digit.
        end
    end

    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            state_q    <= StIdle;
            scan_cnt_q <= '0;
            idx_q      <= 2'd0;
            bcd_a_q    <= 8'h00;
            bcd_b_q    <= 8'h00;
            valid_q    <= 1'b0;
            sel_q      <= 4'b1111;
            seg_q      <= 8'hFF;
        end else begin
            state_q    <= state_d;
            scan_cnt_q <= scan_cnt_d;
            idx_q      <= idx_d;
            bcd_a_q    <= bcd_a_d;
            bcd_b_q    <= bcd_b_d;
            valid_q    <= valid_d;
            sel_q      <= sel_d;
            seg_q      <= seg_d;
        end
    end

    assign sel = sel_q;
    assign seg = seg_q;

endmodule
